// File: rtl/ps2_key_tracker_if.sv
// PS/2 key tracker bus: raw PS/2 pins in, parsed key events and status out.
// master = tracker side, slave = consumer side (drives the PS/2 pins).
interface ps2_key_tracker_if #(
    parameter int CNT_W = 8
);
    logic             ps2_clk;
    logic             ps2_data;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_break;
    logic             key_valid;
    logic             key_down;
    logic [CNT_W-1:0] press_cnt;
    logic             overflow;
    logic             parity_err;

    modport master (
        input  ps2_clk, ps2_data,
        output key_code, key_ext, key_break, key_valid, key_down,
               press_cnt, overflow, parity_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  key_code, key_ext, key_break, key_valid, key_down,
               press_cnt, overflow, parity_err
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receiver, byte FIFO, make/break/E0 parser, held-key tracking.
// Define PS2_PARITY_CHK_EN to drop odd-parity failures and flag them on parity_err.
module ps2_key_tracker #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_key_tracker_if.master     bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    // ---------------- receiver ----------------
    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fall;
    logic          data_bit;
    logic [3:0]    bit_cnt;
    logic [10:0]   shreg;
    logic [10:0]   sh_next;
    logic [TW-1:0] tcnt;
    logic          frame_ok;
    logic          par_ok;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          par_err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], bus.ps2_clk};
            dat_sync <= {dat_sync[0], bus.ps2_data};
        end
    end

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign data_bit = dat_sync[1];

    // Frame is judged on the shift value including the stop bit sampled this cycle.
    always_comb begin
        sh_next  = {data_bit, shreg[10:1]};
        frame_ok = ~sh_next[0] & sh_next[10];
`ifdef PS2_PARITY_CHK_EN
        par_ok   = ^sh_next[9:1];
`else
        par_ok   = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            tcnt      <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            par_err_r <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (fall) begin
                tcnt  <= '0;
                shreg <= sh_next;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        if (par_ok) begin
                            wr_en   <= 1'b1;
                            wr_data <= sh_next[8:1];
                        end else begin
                            par_err_r <= 1'b1;
                        end
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tcnt == TO_LAST) begin
                    bit_cnt <= '0;
                    tcnt    <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic [7:0]  rd_byte;
    logic        ovf_r;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty;
    assign rd_byte = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (wr_en) begin
                if (full) ovf_r  <= 1'b1;
                else      wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // ---------------- parser FSM ----------------
    state_t state;
    state_t state_nx;
    logic   is_e0;
    logic   is_f0;
    logic   ev_fire;
    logic   ev_ext;
    logic   ev_brk;

    assign is_e0 = (rd_byte == 8'hE0);
    assign is_f0 = (rd_byte == 8'hF0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (pop) begin
            unique case (state)
                IDLE:    state_nx = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                EXT:     state_nx = is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
                BRK:     state_nx = is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
                EXT_BRK: state_nx = (is_e0 || is_f0) ? EXT_BRK : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        ev_fire = pop && !is_e0 && !is_f0;
        ev_ext  = (state == EXT) || (state == EXT_BRK);
        ev_brk  = (state == BRK) || (state == EXT_BRK);
    end

    // ---------------- event and held-key tracking ----------------
    logic [7:0]       code_r;
    logic             ext_r;
    logic             brk_r;
    logic             valid_r;
    logic             down_r;
    logic [8:0]       held_r;
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            code_r  <= '0;
            ext_r   <= 1'b0;
            brk_r   <= 1'b0;
            valid_r <= 1'b0;
            down_r  <= 1'b0;
            held_r  <= '0;
            cnt_r   <= '0;
        end else begin
            valid_r <= ev_fire;
            if (ev_fire) begin
                code_r <= rd_byte;
                ext_r  <= ev_ext;
                brk_r  <= ev_brk;
                if (!ev_brk) begin
                    // Only a new key counts; repeats of the held key are typematic.
                    if (!down_r || {ev_ext, rd_byte} != held_r) begin
                        cnt_r  <= cnt_r + 1'b1;
                        down_r <= 1'b1;
                        held_r <= {ev_ext, rd_byte};
                    end
                end else if ({ev_ext, rd_byte} == held_r) begin
                    down_r <= 1'b0;
                end
            end
        end
    end

    assign bus.key_code   = code_r;
    assign bus.key_ext    = ext_r;
    assign bus.key_break  = brk_r;
    assign bus.key_valid  = valid_r;
    assign bus.key_down   = down_r;
    assign bus.press_cnt  = cnt_r;
    assign bus.overflow   = ovf_r;
`ifdef PS2_PARITY_CHK_EN
    assign bus.parity_err = par_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: two instances (normal, and 2-deep FIFO for overflow).
// Events are captured from key_valid pulses and compared against hand-written expectations.
module tb_ps2_key_tracker;
    localparam int H  = 8;
    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   lat;

    always #5 clk = ~clk;

    ps2_key_tracker_if #(.CNT_W(3)) bus1 ();
    ps2_key_tracker_if #(.CNT_W(8)) bus2 ();

    assign bus1.ps2_clk  = ps2_clk;
    assign bus1.ps2_data = ps2_data;
    assign bus2.ps2_clk  = ps2_clk;
    assign bus2.ps2_data = ps2_data;

    ps2_key_tracker #(.FIFO_DEPTH(8), .CNT_W(3), .TIMEOUT_CYC(TO)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    ps2_key_tracker #(.FIFO_DEPTH(2), .CNT_W(8), .TIMEOUT_CYC(TO)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // {ext, brk, code} of every key_valid pulse
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    always @(negedge clk) begin
        if (bus1.key_valid) q1.push_back({bus1.key_ext, bus1.key_break, bus1.key_code});
        if (bus2.key_valid) q2.push_back({bus2.key_ext, bus2.key_break, bus2.key_code});
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d, input bit good);
        logic p;
        p = good ? ~^d : ^d;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clk(H);
            ps2_clk = 1'b0;
            wait_clk(H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(mkframe(d, 1'b1), 11);
        wait_clk(12);
    endtask

    // Counts negedges from the stop-bit falling edge to the key_valid pulse.
    task automatic send_lat(input logic [7:0] d, output int l);
        logic [10:0] f;
        f = mkframe(d, 1'b1);
        send_bits(f, 10);
        ps2_data = f[10];
        wait_clk(H);
        ps2_clk = 1'b0;
        l = -1;
        for (int k = 1; k <= H; k++) begin
            @(negedge clk);
            if (bus1.key_valid && l < 0) l = k;
        end
        ps2_clk = 1'b1;
        wait_clk(12);
    endtask

    task automatic expect_ev(input string tag, input bit second, input logic [9:0] exp);
        logic [31:0] got;
        got = 32'hBAD0;
        if (!second && q1.size() > 0) got = {22'd0, q1.pop_front()};
        if (second && q2.size() > 0)  got = {22'd0, q2.pop_front()};
        check_val(tag, got, {22'd0, exp});
    endtask

    initial begin
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);

        // reset state
        check_val("rst_code",  bus1.key_code, 0);
        check_val("rst_valid", bus1.key_valid, 0);
        check_val("rst_down",  bus1.key_down, 0);
        check_val("rst_cnt",   bus1.press_cnt, 0);
        check_val("rst_ovf",   bus1.overflow, 0);
        check_val("rst_perr",  bus1.parity_err, 0);

        // make/break of A with latency check
        send_lat(8'h1C, lat);
        check_val("latency", lat, 5);
        expect_ev("a_make", 0, 10'h01C);
        check_val("a_cnt", bus1.press_cnt, 1);
        check_val("a_down", bus1.key_down, 1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        expect_ev("a_break", 0, 10'h11C);
        check_val("a_up", bus1.key_down, 0);
        check_val("a_cnt2", bus1.press_cnt, 1);
        check_val("a_qempty", q1.size(), 0);

        // typematic repeat
        for (int i = 0; i < 3; i++) send_byte(8'h1C);
        for (int i = 0; i < 3; i++) expect_ev("rep_ev", 0, 10'h01C);
        check_val("rep_qempty", q1.size(), 0);
        check_val("rep_cnt", bus1.press_cnt, 2);

        // extended make/break
        send_byte(8'hE0);
        send_byte(8'h75);
        expect_ev("ext_make", 0, 10'h275);
        check_val("ext_cnt", bus1.press_cnt, 3);
        check_val("ext_down", bus1.key_down, 1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        expect_ev("ext_break", 0, 10'h375);
        check_val("ext_up", bus1.key_down, 0);

        // held-key tracking with a different key and foreign breaks
        send_byte(8'h1C);
        check_val("h_cnt4", bus1.press_cnt, 4);
        send_byte(8'h32);
        check_val("h_cnt5", bus1.press_cnt, 5);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check_val("h_down_a", bus1.key_down, 1);
        send_byte(8'hF0); send_byte(8'h1C);
        check_val("h_down_b", bus1.key_down, 1);
        send_byte(8'hF0); send_byte(8'h32);
        check_val("h_up", bus1.key_down, 0);
        q1.delete();

        // counter wrap at CNT_W=3
        send_byte(8'h15);
        send_byte(8'h16);
        check_val("w_cnt7", bus1.press_cnt, 7);
        send_byte(8'h15);
        check_val("w_wrap", bus1.press_cnt, 0);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
        q1.delete();
        q1.push_back(10'h000);
        void'(q1.pop_front());
        check_val("brk_e0_code", {bus1.key_ext, bus1.key_break, bus1.key_code}, 10'h375);
        check_val("brk_e0_down", bus1.key_down, 1);
        send_byte(8'hF0); send_byte(8'h15);
        check_val("w_up", bus1.key_down, 0);
        q1.delete();
        q2.delete();

        // overflow with stalled parser on the 2-deep instance
        force dut2.pop = 1'b0;
        send_byte(8'h15);
        send_byte(8'h16);
        send_byte(8'h1A);
        check_val("ovf_set", bus2.overflow, 1);
        check_val("ovf_noev", q2.size(), 0);
        release dut2.pop;
        wait_clk(10);
        expect_ev("ovf_ev1", 1, 10'h015);
        expect_ev("ovf_ev2", 1, 10'h016);
        check_val("ovf_lost", q2.size(), 0);
        check_val("ovf_sticky", bus2.overflow, 1);
        check_val("ovf_other", bus1.overflow, 0);
        q1.delete();

        // partial frame discarded by timeout
        send_bits(mkframe(8'h32, 1'b1), 5);
        wait_clk(TO + 1);
        send_byte(8'h32);
        expect_ev("to_ev", 0, 10'h032);
        check_val("to_qempty", q1.size(), 0);

        // frame with bad parity
        send_bits(mkframe(8'h1C, 1'b0), 11);
        wait_clk(12);
`ifdef PS2_PARITY_CHK_EN
        check_val("par_noev", q1.size(), 0);
        check_val("par_err", bus1.parity_err, 1);
`else
        expect_ev("par_ev", 0, 10'h01C);
        check_val("par_err", bus1.parity_err, 0);
`endif
        q1.delete();

        // reset in the middle of an E0 sequence
        send_byte(8'hE0);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(3);
        check_val("mid_rst_cnt", bus1.press_cnt, 0);
        check_val("mid_rst_ovf", bus2.overflow, 0);
        send_byte(8'h75);
        expect_ev("mid_rst_ev", 0, 10'h075);
        check_val("mid_rst_cnt2", bus1.press_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
